// File: rtl/imm_encoder_if.sv
// Request and instruction-word streams of the immediate encoder.
interface imm_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_kind;
  logic [6:0]  req_opcode;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_last;

  // Producer of requests / consumer of instruction words.
  modport master (
    output req_valid, req_kind, req_opcode, req_funct3, req_rd, req_rs1, req_rs2, req_imm,
    output out_ready,
    input  req_ready, out_valid, out_inst, out_last
  );

  // The encoder itself.
  modport slave (
    input  req_valid, req_kind, req_opcode, req_funct3, req_rd, req_rs1, req_rs2, req_imm,
    input  out_ready,
    output req_ready, out_valid, out_inst, out_last
  );
endinterface

// File: rtl/imm_encoder.sv
// Range-checks an immediate, scatters it into an RV32I instruction format and
// streams the word out; expands LI into ADDI or LUI+ADDI.
module imm_encoder #(
  parameter int unsigned ERR_CNT_W  = 8,
  parameter int unsigned LI_COMPACT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imm_encoder_if.slave         bus,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;
  typedef enum logic [2:0] {
    K_I = 3'b000, K_S = 3'b001, K_B = 3'b010, K_U = 3'b011, K_J = 3'b100, K_LI = 3'b101
  } kind_t;

  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  state_t                state_q, state_d;
  logic [31:0]           inst_q, inst_d;
  logic [31:0]           word2_q, word2_d;
  logic                  last_q, last_d;
  logic                  err_q, err_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic [31:0] imm;
  logic [31:0] li_sum;
  logic        fits12, fits13, fits21;
  logic        legal, two_word;
  logic [31:0] word1, word2;
  logic        accept;

  assign imm    = bus.req_imm;
  assign li_sum = imm + 32'h0000_0800;
  // Sign-bit runs: the value fits an N-bit signed field when bits [31:N-1] agree.
  assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

  assign accept        = bus.req_valid & (state_q == IDLE);
  assign bus.req_ready = (state_q == IDLE);
  assign bus.out_valid = (state_q != IDLE);
  assign bus.out_inst  = inst_q;
  assign bus.out_last  = last_q;
  assign err           = err_q;
  assign err_cnt       = err_cnt_q;

  // Legality and the word(s) a request encodes to.
  always_comb begin
    legal    = 1'b0;
    two_word = 1'b0;
    word1    = '0;
    word2    = '0;
    case (bus.req_kind)
      K_I: begin
        legal = fits12;
        word1 = {imm[11:0], bus.req_rs1, bus.req_funct3, bus.req_rd, bus.req_opcode};
      end
      K_S: begin
        legal = fits12;
        word1 = {imm[11:5], bus.req_rs2, bus.req_rs1, bus.req_funct3, imm[4:0], bus.req_opcode};
      end
      K_B: begin
        // fits13 allows up to 4095; the even-ness test caps it at 4094.
        legal = fits13 & ~imm[0];
        word1 = {imm[12], imm[10:5], bus.req_rs2, bus.req_rs1, bus.req_funct3,
                 imm[4:1], imm[11], bus.req_opcode};
      end
      K_U: begin
        legal = ~(|imm[11:0]);
        word1 = {imm[31:12], bus.req_rd, bus.req_opcode};
      end
      K_J: begin
        legal = fits21 & ~imm[0];
        word1 = {imm[20], imm[10:1], imm[11], imm[19:12], bus.req_rd, bus.req_opcode};
      end
      K_LI: begin
        legal = 1'b1;
        if ((LI_COMPACT != 0) && fits12) begin
          word1 = {imm[11:0], 5'd0, 3'b000, bus.req_rd, OP_ADDI};
        end else begin
          // Rounding by 0x800 pre-compensates the sign extension of the ADDI low part.
          two_word = 1'b1;
          word1    = {li_sum[31:12], bus.req_rd, OP_LUI};
          word2    = {imm[11:0], bus.req_rd, 3'b000, bus.req_rd, OP_ADDI};
        end
      end
      default: legal = 1'b0;
    endcase
  end

  // Next-state, output-word and error-counter logic.
  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    word2_d   = word2_q;
    last_d    = last_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (legal) begin
            state_d = EMIT1;
            inst_d  = word1;
            word2_d = word2;
            last_d  = ~two_word;
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
          end
        end
      end
      EMIT1: begin
        if (bus.out_ready) begin
          if (!last_q) begin
            state_d = EMIT2;
            inst_d  = word2_q;
            last_d  = 1'b1;
          end else begin
            state_d = IDLE;
            last_d  = 1'b0;
          end
        end
      end
      EMIT2: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      inst_q    <= '0;
      word2_q   <= '0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      word2_q   <= word2_d;
      last_q    <= last_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed cases plus a randomized sweep
// checked against an ImmGen-style decoder and arithmetic legality model.
module tb_imm_encoder;
  localparam int unsigned ERR_CNT_W = 8;
  localparam int unsigned ERR_MAX   = (1 << ERR_CNT_W) - 1;

  logic clk;
  logic rst_n;
  logic err;
  logic [ERR_CNT_W-1:0] err_cnt;

  imm_encoder_if bus_if ();

  imm_encoder #(.ERR_CNT_W(ERR_CNT_W), .LI_COMPACT(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_if),
    .err     (err),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int exp_errs = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  // Reference legality from signed ranges.
  function automatic bit model_legal(input logic [2:0] kind, input logic [31:0] imm);
    int s;
    s = $signed(imm);
    case (kind)
      3'd0, 3'd1: return (s >= -2048) && (s <= 2047);
      3'd2:       return (s >= -4096) && (s <= 4094) && (s % 2 == 0);
      3'd3:       return (imm % 4096) == 0;
      3'd4:       return (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
      3'd5:       return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  // Immediate recovered from a word the way the core's ImmGen does it.
  function automatic logic [31:0] decode_imm(input logic [2:0] kind, input logic [31:0] w);
    case (kind)
      3'd0:    return sext12(w[31:20]);
      3'd1:    return sext12({w[31:25], w[11:7]});
      3'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd3:    return {w[31:12], 12'd0};
      default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  task automatic send_req(input logic [2:0] kind, input logic [6:0] op, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] imm);
    int waited;
    waited = 0;
    while (bus_if.req_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (bus_if.req_ready !== 1'b1) check("req_ready_timeout", {31'd0, bus_if.req_ready}, 32'd1);
    bus_if.req_kind   = kind;
    bus_if.req_opcode = op;
    bus_if.req_funct3 = f3;
    bus_if.req_rd     = rd;
    bus_if.req_rs1    = rs1;
    bus_if.req_rs2    = rs2;
    bus_if.req_imm    = imm;
    bus_if.req_valid  = 1'b1;
    @(posedge clk); #1;
    bus_if.req_valid  = 1'b0;
  endtask

  // Send one request, collect its words with 'stall' cycles of backpressure per
  // word, and check them against the reference model.
  task automatic do_req(input logic [2:0] kind, input logic [6:0] op, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input int stall,
                        output logic [31:0] w0, output logic [31:0] w1);
    bit legal;
    int nw;
    int s;
    logic [31:0] w [2];
    logic [31:0] held;
    legal = model_legal(kind, imm);
    s = $signed(imm);
    if (!legal) nw = 0;
    else if (kind == 3'd5) nw = (s >= -2048 && s <= 2047) ? 1 : 2;
    else nw = 1;
    w[0] = '0;
    w[1] = '0;
    bus_if.out_ready = (stall == 0);
    send_req(kind, op, f3, rd, rs1, rs2, imm);
    if (!legal) begin
      if (exp_errs < ERR_MAX) exp_errs++;
      check("drop_no_valid", {31'd0, bus_if.out_valid}, 32'd0);
      check("err_pulse", {31'd0, err}, 32'd1);
      check("err_cnt", 32'(err_cnt), 32'(exp_errs));
      @(posedge clk); #1;
      check("err_clear", {31'd0, err}, 32'd0);
    end else begin
      for (int i = 0; i < nw; i++) begin
        held = bus_if.out_inst;
        for (int c = 0; c < stall; c++) begin
          bus_if.out_ready = 1'b0;
          check("stall_valid", {31'd0, bus_if.out_valid}, 32'd1);
          check("stall_hold", bus_if.out_inst, held);
          check("stall_no_ready", {31'd0, bus_if.req_ready}, 32'd0);
          @(posedge clk); #1;
        end
        bus_if.out_ready = 1'b1;
        check("word_valid", {31'd0, bus_if.out_valid}, 32'd1);
        check("word_last", {31'd0, bus_if.out_last}, {31'd0, i == nw - 1});
        w[i] = bus_if.out_inst;
        @(posedge clk); #1;
      end
      check("done_idle_valid", {31'd0, bus_if.out_valid}, 32'd0);
      check("done_ready", {31'd0, bus_if.req_ready}, 32'd1);
      if (kind != 3'd5) begin
        check("roundtrip", decode_imm(kind, w[0]), imm);
        case (kind)
          3'd0:       check("fields_i", w[0] & 32'h000F_FFFF,
                            (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op));
          3'd1, 3'd2: check("fields_sb", w[0] & 32'h01FF_F07F,
                            (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op));
          default:    check("fields_uj", w[0] & 32'h0000_0FFF, (32'(rd) << 7) | 32'(op));
        endcase
      end else if (nw == 1) begin
        check("li1_fields", w[0] & 32'h000F_FFFF, (32'(rd) << 7) | 32'h13);
        check("li1_value", sext12(w[0][31:20]), imm);
      end else begin
        check("li2_lui", w[0] & 32'h0000_0FFF, (32'(rd) << 7) | 32'h37);
        check("li2_addi", w[1] & 32'h000F_FFFF, (32'(rd) << 15) | (32'(rd) << 7) | 32'h13);
        check("li2_value", {w[0][31:12], 12'd0} + sext12(w[1][31:20]), imm);
      end
    end
    w0 = w[0];
    w1 = w[1];
  endtask

  initial begin
    logic [31:0] w0, w1, imm;
    logic [2:0]  kind;
    int stall;

    bus_if.req_valid  = 1'b0;
    bus_if.req_kind   = '0;
    bus_if.req_opcode = '0;
    bus_if.req_funct3 = '0;
    bus_if.req_rd     = '0;
    bus_if.req_rs1    = '0;
    bus_if.req_rs2    = '0;
    bus_if.req_imm    = '0;
    bus_if.out_ready  = 1'b1;
    rst_n = 1'b0;
    #12;
    check("rst_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check("rst_out_inst", bus_if.out_inst, 32'd0);
    check("rst_out_last", {31'd0, bus_if.out_last}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    do_req(3'd0, 7'h13, 3'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 0, w0, w1);
    check("addi_m1", w0, 32'hFFF0_0293);
    do_req(3'd4, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 0, w0, w1);
    check("jal_m4", w0, 32'hFFDF_F06F);
    do_req(3'd4, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd0, 32'd3, 0, w0, w1);
    check("jal_odd_cnt", 32'(err_cnt), 32'd1);
    do_req(3'd5, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 32'h1234_5FFF, 0, w0, w1);
    check("li_w1", w0, 32'h1234_60B7);
    check("li_w2", w1, 32'hFFF0_8093);
    do_req(3'd5, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 0, w0, w1);
    check("li_small", w0, 32'h0050_0093);
    do_req(3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd4096, 0, w0, w1);
    do_req(3'd1, 7'h23, 3'd2, 5'd0, 5'd1, 5'd2, 32'hFFFF_F7FF, 0, w0, w1);
    check("two_drops_cnt", 32'(err_cnt), 32'd3);

    // Reserved kind held valid: one drop per cycle until the counter saturates.
    bus_if.req_kind  = 3'd6;
    bus_if.req_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (exp_errs < ERR_MAX) exp_errs++;
    end
    check("sat_cnt", 32'(err_cnt), 32'(exp_errs));
    check("sat_err", {31'd0, err}, 32'd1);
    bus_if.req_valid = 1'b0;
    @(posedge clk); #1;
    check("sat_err_clear", {31'd0, err}, 32'd0);
    check("sat_cnt_hold", 32'(err_cnt), 32'd255);

    // LI pair under 5 cycles of backpressure per word.
    do_req(3'd5, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 32'h1234_5FFF, 5, w0, w1);
    check("bp_w1", w0, 32'h1234_60B7);
    check("bp_w2", w1, 32'hFFF0_8093);

    // Reset while the second LI word is pending.
    bus_if.out_ready = 1'b1;
    send_req(3'd5, 7'h00, 3'd0, 5'd3, 5'd0, 5'd0, 32'h7FFF_F000 + 32'h900);
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
    check("emit2_last", {31'd0, bus_if.out_last}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check("mid_rst_inst", bus_if.out_inst, 32'd0);
    check("mid_rst_last", {31'd0, bus_if.out_last}, 32'd0);
    check("mid_rst_cnt", 32'(err_cnt), 32'd0);
    exp_errs = 0;
    @(negedge clk); rst_n = 1'b1;
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", {31'd0, bus_if.req_ready}, 32'd1);
    check("post_rst_valid", {31'd0, bus_if.out_valid}, 32'd0);

    // Randomized sweep, mostly legal immediates, some illegal and reserved.
    for (int n = 0; n < 300; n++) begin
      kind = 3'($urandom_range(0, 5));
      case (kind)
        3'd0, 3'd1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        3'd2:       imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
        3'd3:       imm = $urandom & 32'hFFFF_F000;
        3'd4:       imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
        default:    imm = ($urandom_range(0, 1) != 0) ? $urandom
                                                      : 32'($urandom_range(0, 4095)) - 32'd2048;
      endcase
      if ($urandom_range(0, 7) == 0) imm = $urandom;
      if ($urandom_range(0, 15) == 0) kind = 3'($urandom_range(6, 7));
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_req(kind, 7'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             imm, stall, w0, w1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
